// File: rtl/tone_seq_pkg.sv
// Shared types and defaults for the programmable tone sequencer.
package tone_seq_pkg;

  localparam int TICK_DIV_DEF = 50000;
  localparam int HP_W_DEF     = 20;
  localparam int DUR_W_DEF    = 12;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PLAY,
    GAP
  } state_t;

  // Note-table entry layout at the default field widths.
  typedef struct packed {
    logic [HP_W_DEF-1:0]  half_period;
    logic [DUR_W_DEF-1:0] duration;
  } note_t;

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles every half_period cycles, silent while restart or half_period=0.
module tone_gen #(
  parameter int HP_W = 20
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            restart,
  input  logic [HP_W-1:0] half_period,
  output logic            speaker
);

  logic [HP_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      speaker <= 1'b0;
    end else if (restart || (half_period == '0)) begin
      cnt_q   <= '0;
      speaker <= 1'b0;
    end else if (cnt_q == half_period - HP_W'(1)) begin
      cnt_q   <= '0;
      speaker <= ~speaker;
    end else begin
      cnt_q <= cnt_q + HP_W'(1);
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Plays a run-time programmable table of square-wave notes on one speaker pin.
//   state | meaning
//   IDLE  | waiting for start, speaker silent
//   FETCH | table entry at note_idx being read (1 cycle)
//   PLAY  | note sounding for max(duration,1) ticks
//   GAP   | silent GAP_TICKS ticks after a note
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int HP_W      = 20,
  parameter int DUR_W     = 12,
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int GAP_TICKS = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [HP_W-1:0]          wr_half_period,
  input  logic [DUR_W-1:0]         wr_duration,
  input  logic [$clog2(DEPTH):0]   seq_len,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] note_idx,
  output logic                     done,
  output logic                     speaker
);

  localparam int AW       = $clog2(DEPTH);
  localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
  localparam bit HAS_GAP  = (GAP_TICKS > 0);

  typedef struct packed {
    logic [HP_W-1:0]  half_period;
    logic [DUR_W-1:0] duration;
  } entry_t;

  entry_t          note_mem [DEPTH];
  entry_t          cur_q;
  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW:0]     len_q, len_d;
  logic            done_d;
  logic [PS_W-1:0] ps_q;
  logic [DUR_W-1:0] tick_q, tick_last;
  logic            timing, ps_wrap, phase_end, note_done, last_note, start_ok;
  logic [HP_W-1:0] gen_hp;

  always_ff @(posedge clk) begin
    if (wr_en) note_mem[wr_addr] <= entry_t'{half_period: wr_half_period, duration: wr_duration};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               cur_q <= '0;
    else if (state_q == FETCH) cur_q <= note_mem[idx_q];
  end

  assign timing    = (state_q == PLAY) || (state_q == GAP);
  assign ps_wrap   = (ps_q == PS_W'(TICK_DIV - 1));
  assign tick_last = (state_q == GAP)            ? DUR_W'(GAP_LAST) :
                     (cur_q.duration == '0)      ? '0 :
                                                   cur_q.duration - DUR_W'(1);
  assign phase_end = timing && ps_wrap && (tick_q == tick_last);
  assign note_done = phase_end && ((state_q == GAP) || !HAS_GAP);
  assign last_note = ({1'b0, idx_q} == len_q - (AW+1)'(1));
  assign start_ok  = start && !stop && (seq_len != '0) && (seq_len <= (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ps_q   <= '0;
      tick_q <= '0;
    end else if (!timing || phase_end || stop) begin
      ps_q   <= '0;
      tick_q <= '0;
    end else if (ps_wrap) begin
      ps_q   <= '0;
      tick_q <= tick_q + DUR_W'(1);
    end else begin
      ps_q <= ps_q + PS_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = FETCH;
          idx_d   = '0;
          len_d   = seq_len;
        end
      end
      FETCH:   state_d = PLAY;
      PLAY:    if (phase_end && HAS_GAP) state_d = GAP;
      default: ;
    endcase
    if (note_done) begin
      if (!last_note) begin
        idx_d   = idx_q + AW'(1);
        state_d = FETCH;
      end else if (loop_en) begin
        idx_d   = '0;
        state_d = FETCH;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
    // Abort wins over everything, including a start in the same cycle.
    if (stop) begin
      state_d = IDLE;
      idx_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      done    <= done_d;
    end
  end

  // Holding the generator in restart whenever PLAY is not next silences it on every exit.
  assign gen_hp = (state_q == PLAY) ? cur_q.half_period : '0;

  tone_gen #(.HP_W(HP_W)) u_tone_gen (
    .clk         (clk),
    .resetn      (resetn),
    .restart     (state_d != PLAY),
    .half_period (gen_hp),
    .speaker     (speaker)
  );

  assign busy     = (state_q != IDLE);
  assign note_idx = idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with TICK_DIV=4; a second instance covers GAP_TICKS=1.
module tb_tone_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_half_period = '0;
  logic [3:0] wr_duration = '0;
  logic [2:0] seq_len = '0;
  logic       loop_en = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;

  logic       busy, done, speaker;
  logic [1:0] note_idx;
  logic       g_busy, g_done, g_speaker;
  logic [1:0] g_note_idx;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tone_sequencer #(.DEPTH(4), .HP_W(8), .DUR_W(4), .TICK_DIV(4), .GAP_TICKS(0)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_half_period(wr_half_period), .wr_duration(wr_duration), .seq_len(seq_len),
    .loop_en(loop_en), .start(start), .stop(stop), .busy(busy), .note_idx(note_idx),
    .done(done), .speaker(speaker)
  );

  tone_sequencer #(.DEPTH(4), .HP_W(8), .DUR_W(4), .TICK_DIV(4), .GAP_TICKS(1)) dut_gap (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_half_period(wr_half_period), .wr_duration(wr_duration), .seq_len(seq_len),
    .loop_en(loop_en), .start(start), .stop(stop), .busy(g_busy), .note_idx(g_note_idx),
    .done(g_done), .speaker(g_speaker)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int addr, input int hp, input int dur);
    wr_en = 1'b1;
    wr_addr = 2'(addr);
    wr_half_period = 8'(hp);
    wr_duration = 4'(dur);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_seq(input int len);
    seq_len = 3'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered in the FETCH cycle; returns in the cycle after the last PLAY cycle.
  task automatic expect_note(input int idx, input int hp, input int ncyc);
    check_eq("fetch_busy", 32'(busy), 1);
    check_eq("fetch_idx", 32'(note_idx), idx);
    check_eq("fetch_spk", 32'(speaker), 0);
    tick();
    for (int k = 0; k < ncyc; k++) begin
      check_eq("play_spk", 32'(speaker), (hp == 0) ? 0 : (k / hp) % 2);
      check_eq("play_idx", 32'(note_idx), idx);
      check_eq("play_done", 32'(done), 0);
      tick();
    end
  endtask

  task automatic expect_end();
    check_eq("end_done", 32'(done), 1);
    check_eq("end_busy", 32'(busy), 0);
    check_eq("end_spk", 32'(speaker), 0);
    tick();
    check_eq("done_pulse_len", 32'(done), 0);
  endtask

  initial begin
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_idx", 32'(note_idx), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_spk", 32'(speaker), 0);
    #10 resetn = 1'b1;
    tick();

    // basic single note
    write_entry(0, 3, 2);
    start_seq(1);
    expect_note(0, 3, 8);
    expect_end();

    // multi-note with a rest
    write_entry(0, 2, 1);
    write_entry(1, 0, 1);
    write_entry(2, 5, 1);
    start_seq(3);
    expect_note(0, 2, 4);
    expect_note(1, 0, 4);
    expect_note(2, 5, 4);
    expect_end();

    // loop, then release loop during entry 1
    loop_en = 1'b1;
    start_seq(2);
    expect_note(0, 2, 4);
    expect_note(1, 0, 4);
    expect_note(0, 2, 4);
    loop_en = 1'b0;
    expect_note(1, 0, 4);
    expect_end();

    // stop during entry 1
    start_seq(2);
    expect_note(0, 2, 4);
    tick();
    check_eq("pre_stop_idx", 32'(note_idx), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("stop_busy", 32'(busy), 0);
    check_eq("stop_idx", 32'(note_idx), 0);
    check_eq("stop_done", 32'(done), 0);
    tick();
    check_eq("stop_done_late", 32'(done), 0);

    // stop while speaker high
    start_seq(1);
    tick(); tick(); tick();
    check_eq("pre_stop_spk", 32'(speaker), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("stop_spk", 32'(speaker), 0);
    check_eq("stop_busy2", 32'(busy), 0);

    // start and stop together from IDLE
    seq_len = 3'd1;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check_eq("start_stop_busy", 32'(busy), 0);
    tick();
    check_eq("start_stop_busy2", 32'(busy), 0);

    // illegal lengths
    start_seq(0);
    check_eq("len0_busy", 32'(busy), 0);
    start_seq(5);
    check_eq("len5_busy", 32'(busy), 0);

    // zero duration acts as one tick
    write_entry(0, 1, 0);
    start_seq(1);
    expect_note(0, 1, 4);
    expect_end();

    // start while busy leaves the sequence alone
    write_entry(0, 2, 1);
    start_seq(2);
    expect_note(0, 2, 4);
    tick();
    seq_len = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("busy_start_idx", 32'(note_idx), 1);
    check_eq("busy_start_busy", 32'(busy), 1);
    tick(); tick(); tick();
    expect_end();

    // rewrite entry 1 while entry 0 plays
    start_seq(2);
    tick();
    write_entry(1, 1, 1);
    tick(); tick(); tick();
    expect_note(1, 1, 4);
    expect_end();

    // async reset mid-note
    start_seq(1);
    tick(); tick(); tick();
    check_eq("pre_rst_spk", 32'(speaker), 1);
    #2 resetn = 1'b0;
    #2;
    check_eq("midrst_spk", 32'(speaker), 0);
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_done", 32'(done), 0);
    #2 resetn = 1'b1;
    tick();
    start_seq(1);
    expect_note(0, 2, 4);
    expect_end();
    repeat (6) tick();

    // GAP_TICKS=1 instance
    write_entry(1, 3, 1);
    start_seq(2);
    for (int n = 0; n < 2; n++) begin
      check_eq("gap_fetch_idx", 32'(g_note_idx), n);
      check_eq("gap_fetch_spk", 32'(g_speaker), 0);
      check_eq("gap_fetch_busy", 32'(g_busy), 1);
      tick();
      for (int k = 0; k < 4; k++) begin
        check_eq("gap_play_spk", 32'(g_speaker), (k / (n == 0 ? 2 : 3)) % 2);
        tick();
      end
      for (int k = 0; k < 4; k++) begin
        check_eq("gap_silent_spk", 32'(g_speaker), 0);
        check_eq("gap_silent_busy", 32'(g_busy), 1);
        check_eq("gap_silent_idx", 32'(g_note_idx), n);
        tick();
      end
    end
    check_eq("gap_done", 32'(g_done), 1);
    check_eq("gap_end_busy", 32'(g_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Parametrised successor to the fixed-scale audio block: plays a programmable sequence of square-wave notes on a single speaker pin.
- Each entry in a writable note table holds a half-period count and a duration, so pitch and rhythm are set at run time with no runtime division.
- Adds start/stop control, loop mode, rests, an optional inter-note gap and a done pulse.
- Sits between the game/control logic (table writes, start/stop) and the audio output pin.

Parameters:
- DEPTH, 16: note table entries (power of 2, ≥2).
- HP_W, 20: half-period counter width, in clk cycles.
- DUR_W, 12: duration field width, in ticks.
- TICK_DIV, 50000: clk cycles per duration tick (1 ms at 50 MHz).
- GAP_TICKS, 0: silent ticks inserted after every note (0 = no gap).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- wr_en  in  1  write note entry this cycle
- wr_addr  in  $clog2(DEPTH)  table address
- wr_half_period  in  HP_W  clk cycles per half wave; 0 = rest
- wr_duration  in  DUR_W  note length in ticks; 0 treated as 1
- seq_len  in  $clog2(DEPTH)+1  number of entries to play (1..DEPTH)
- loop_en  in  1  restart from entry 0 after the last entry
- start  in  1  single-cycle start request
- stop  in  1  single-cycle abort request
- busy  out  1  high in any state other than IDLE
- note_idx  out  $clog2(DEPTH)  entry currently fetched or playing
- done  out  1  one-cycle pulse when a non-looping sequence completes
- speaker  out  1  square-wave output

Behaviour:
- Reset (async, resetn=0): state IDLE; busy=0, note_idx=0, done=0, speaker=0; all counters 0.
- Table contents are not reset.
- Table: DEPTH×(HP_W+DUR_W) registers.
  - Write is synchronous and allowed in any state.
  - Read is registered: the address is presented in FETCH and the data is used on PLAY entry.
  - Writing an entry during play affects it only at its next fetch.
- Sampling: seq_len is latched on an accepted start; later changes are ignored until the next start. loop_en is sampled live when the last note ends.
- States: IDLE, FETCH, PLAY, GAP.
- IDLE:
  - start=1, stop=0, latched length > 0 → FETCH, note_idx=0.
  - start with seq_len=0 or seq_len>DEPTH is ignored.
  - start while busy is ignored.
- FETCH (1 cycle) → PLAY. On entry to PLAY: speaker=0, half-period counter=0, tick prescaler=0, tick counter=0.
- PLAY:
  - If half_period≠0, speaker toggles every half_period cycles; the first toggle occurs half_period cycles after PLAY entry.
  - If half_period=0, speaker is held 0.
  - PLAY lasts exactly max(duration,1)×TICK_DIV cycles.
  - Exit → GAP if GAP_TICKS>0, otherwise the note-end decision.
- GAP: speaker=0 for GAP_TICKS×TICK_DIV cycles, then the note-end decision.
- Note-end decision:
  - note_idx < len−1 → note_idx+1, FETCH.
  - Last entry with loop_en=1 → note_idx=0, FETCH. No done pulse.
  - Last entry with loop_en=0 → IDLE, done=1 for one cycle, speaker=0.
- Cycle count: a start accepted at cycle t gives FETCH at t+1 and PLAY at t+2. With GAP_TICKS=0, the gap between consecutive PLAY periods is exactly the 1-cycle FETCH.
- stop=1 in any state: IDLE next cycle, speaker=0, note_idx=0, no done pulse. stop has priority over start in the same cycle.
- Counters: half-period counter is HP_W bits; prescaler is $clog2(TICK_DIV) bits; tick counter is DUR_W bits. Compares are exact equality; no wrap occurs within a note.
- Reset asserted mid-note: immediate silence; no done pulse.

Decomposition:
- Package tone_seq_pkg:
  - state enum {IDLE, FETCH, PLAY, GAP}.
  - Note-entry struct {half_period, duration}.
  - Default TICK_DIV constant.
- Sub-module tone_gen:
  - Inputs: clk, resetn, restart, half_period.
  - Output: speaker.
  - Contains the half-period counter and toggle flop; used for both PLAY and silence.
- Prescaler, tick counter, FSM and table stay in the top module.

Test Plan:
All scenarios use TICK_DIV=4 and GAP_TICKS=0 unless stated.
- Basic: entry0={hp=3,dur=2}, seq_len=1, start at t0 → PLAY from t0+2 for 8 cycles; speaker toggles at +3 and +6; done pulses one cycle after PLAY ends; busy falls the same cycle.
- Multi-note and rest: entries {2,1},{0,1},{5,1}, seq_len=3 → note_idx goes 0,1,2; speaker stays 0 throughout entry1; one FETCH cycle between notes; a single done pulse.
- Loop: seq_len=2, loop_en=1 → note_idx sequence 0,1,0,1… with no done pulse. Clear loop_en during entry1 → done after entry1 ends.
- Stop and priority: stop mid-PLAY → busy=0 and speaker=0 next cycle, no done pulse. start and stop in the same cycle from IDLE → remains IDLE.
- Edges:
  - Duration 0 lasts 4 cycles.
  - seq_len=0 start is ignored.
  - start while busy does not reset note_idx.
  - A write to entry1 during entry0 takes effect at entry1's fetch.
  - GAP_TICKS=1 gives 4 silent cycles plus FETCH between notes.
- Reset: resetn low mid-note (asynchronously, between clk edges) → speaker, busy and done are 0 immediately; after release, a start replays from entry0 with the table intact.
